// File: rtl/freelist_ctrl.sv
// ---------------------------------------------------------------------------
// freelist_ctrl
//
// Sequencer in front of the physical-register freelist. It grants rename
// allocations all-or-nothing, forwards the registers the freelist pops one
// cycle later, and queues commit-time releases onto the freelist push port.
// Every uncommitted allocation is kept in an in-flight ring. On a flush the
// ring is walked newest-first and its registers go back to the freelist,
// two per cycle.
//
// Optional feature macro: FREELIST_CTRL_STATS_EN
//   When defined, two 32-bit saturating counters are added and exported on
//   stat_alloc_stall and stat_recovered.
//
// Ports
//   clk             clock
//   rst             asynchronous reset, active low
//   rn_req          per-slot allocation request from rename
//   rn_ready        grant for all requested slots this cycle
//   rn_alloc_valid  registered: slot carries an allocated register
//   rn_alloc_reg    allocated register number per slot
//   cm_retire_en    per-slot commit; retires the oldest ring entry per bit
//   cm_free_en      per-slot release of an old mapping
//   cm_free_reg     register released per slot
//   cm_ready        release queue can take two more entries
//   flush           discard all uncommitted allocations
//   flush_busy      recovery walk in progress (state == RECOVER)
//   fl_pop_en       freelist pop request
//   fl_pop_reg      freelist pop data, valid the cycle after fl_pop_en
//   fl_empty        freelist cannot serve a full dispatch group
//   fl_push_en      freelist push request
//   fl_push_reg     freelist push data
//   stat_alloc_stall, stat_recovered   (FREELIST_CTRL_STATS_EN only)
//
// Handshakes: rn_req is granted only as a whole group while rn_ready is high
// in the same cycle; cm_free_en entries are taken only while cm_ready is high
// in the same cycle and are dropped otherwise; the freelist push and pop
// ports have no back-pressure and are consumed whenever enabled.
// ---------------------------------------------------------------------------
module freelist_ctrl #(
    parameter int DISPATCH_WIDTH       = 2,
    parameter int PHYS_REGS            = 64,
    parameter int PHYS_REGS_ADDR_WIDTH = 6,
    parameter int INFLIGHT_DEPTH       = 32,
    parameter int RELQ_DEPTH           = 4
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [DISPATCH_WIDTH-1:0]                      rn_req,
    output logic                                           rn_ready,
    output logic [DISPATCH_WIDTH-1:0]                      rn_alloc_valid,
    output logic [DISPATCH_WIDTH*PHYS_REGS_ADDR_WIDTH-1:0] rn_alloc_reg,
    input  logic [DISPATCH_WIDTH-1:0]                      cm_retire_en,
    input  logic [DISPATCH_WIDTH-1:0]                      cm_free_en,
    input  logic [DISPATCH_WIDTH*PHYS_REGS_ADDR_WIDTH-1:0] cm_free_reg,
    output logic                                           cm_ready,
    input  logic                                           flush,
    output logic                                           flush_busy,
    output logic [DISPATCH_WIDTH-1:0]                      fl_pop_en,
    input  logic [DISPATCH_WIDTH*PHYS_REGS_ADDR_WIDTH-1:0] fl_pop_reg,
    input  logic                                           fl_empty,
    output logic [DISPATCH_WIDTH-1:0]                      fl_push_en,
    output logic [DISPATCH_WIDTH*PHYS_REGS_ADDR_WIDTH-1:0] fl_push_reg
`ifdef FREELIST_CTRL_STATS_EN
    ,
    output logic [31:0]                                    stat_alloc_stall,
    output logic [31:0]                                    stat_recovered
`endif
);

    localparam int AW  = PHYS_REGS_ADDR_WIDTH;
    localparam int IPW = $clog2(INFLIGHT_DEPTH);
    localparam int ICW = IPW + 1;
    localparam int QPW = $clog2(RELQ_DEPTH);
    localparam int QCW = QPW + 1;

    localparam logic [ICW-1:0] C_RING_DEPTH = ICW'(INFLIGHT_DEPTH);
    localparam logic [ICW-1:0] C_RING_TWO   = ICW'(2);
    localparam logic [QCW-1:0] C_RQ_DEPTH   = QCW'(RELQ_DEPTH);
    localparam logic [QCW-1:0] C_RQ_TWO     = QCW'(2);

    // The slot logic below is written out for exactly two slots.
    if (DISPATCH_WIDTH != 2 || $clog2(PHYS_REGS) != PHYS_REGS_ADDR_WIDTH) begin : g_bad_cfg
        $error("freelist_ctrl: DISPATCH_WIDTH must be 2 and PHYS_REGS_ADDR_WIDTH must be clog2(PHYS_REGS)");
    end

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic [1:0]     r_alloc_valid;
    logic [AW-1:0]  r_ring [INFLIGHT_DEPTH];
    logic [IPW-1:0] r_head;
    logic [IPW-1:0] r_tail;
    logic [ICW-1:0] r_ring_cnt;
    logic [AW-1:0]  r_relq [RELQ_DEPTH];
    logic [QPW-1:0] r_rq_wr;
    logic [QPW-1:0] r_rq_rd;
    logic [QCW-1:0] r_rq_cnt;

    // -----------------------------------------------------------------------
    // Combinational datapath
    // -----------------------------------------------------------------------
    logic [ICW-1:0] w_wr_n;
    logic [ICW-1:0] w_ret_n;
    logic [ICW-1:0] w_rec_n;
    logic [ICW-1:0] w_cnt_post;
    logic [ICW-1:0] w_free_after;
    logic [AW-1:0]  w_wr_d0;
    logic [AW-1:0]  w_wr_d1;
    logic [IPW-1:0] w_rec_idx0;
    logic [IPW-1:0] w_rec_idx1;
    logic [AW-1:0]  w_rec_d0;
    logic [AW-1:0]  w_rec_d1;
    logic [QCW-1:0] w_enq_n;
    logic [QCW-1:0] w_deq_n;
    logic [AW-1:0]  w_enq_d0;
    logic [AW-1:0]  w_enq_d1;
    logic [QPW-1:0] w_rq_rd1;
    logic           w_run;

    assign w_run = (r_state == ST_RUN);

    // Pop data arriving this cycle is written to the ring in slot order, so a
    // lone slot-1 allocation still lands in the first free ring position.
    assign w_wr_n  = ICW'(r_alloc_valid[0]) + ICW'(r_alloc_valid[1]);
    assign w_wr_d0 = r_alloc_valid[0] ? fl_pop_reg[0 +: AW] : fl_pop_reg[AW +: AW];
    assign w_wr_d1 = fl_pop_reg[AW +: AW];

    assign w_ret_n = ICW'(cm_retire_en[0]) + ICW'(cm_retire_en[1]);

    // Ring occupancy once this cycle's writes and retires are applied; a flush
    // only recovers what is left after the retire.
    assign w_cnt_post = r_ring_cnt + w_wr_n - w_ret_n;

    // Free-slot check accounts for pop data landing this cycle but not for
    // retires, so a grant never relies on a same-cycle commit.
    assign w_free_after = C_RING_DEPTH - r_ring_cnt - w_wr_n;

    assign rn_ready  = w_run && !flush && !fl_empty && (w_free_after >= C_RING_TWO);
    assign fl_pop_en = rn_ready ? rn_req : 2'b00;

    // Recovery walks from the head: newest entry on slot 0.
    assign w_rec_n    = (r_state == ST_RECOVER) ?
                        ((r_ring_cnt >= C_RING_TWO) ? C_RING_TWO : r_ring_cnt) : '0;
    assign w_rec_idx0 = r_head - IPW'(1);
    assign w_rec_idx1 = r_head - IPW'(2);
    assign w_rec_d0   = r_ring[w_rec_idx0];
    assign w_rec_d1   = r_ring[w_rec_idx1];

    // Release queue: accepts while two entries are free, drains only in RUN.
    assign cm_ready = ((C_RQ_DEPTH - r_rq_cnt) >= C_RQ_TWO);
    assign w_enq_n  = cm_ready ? (QCW'(cm_free_en[0]) + QCW'(cm_free_en[1])) : '0;
    assign w_enq_d0 = cm_free_en[0] ? cm_free_reg[0 +: AW] : cm_free_reg[AW +: AW];
    assign w_enq_d1 = cm_free_reg[AW +: AW];
    assign w_deq_n  = w_run ? ((r_rq_cnt >= C_RQ_TWO) ? C_RQ_TWO : r_rq_cnt) : '0;
    assign w_rq_rd1 = r_rq_rd + QPW'(1);

    // Allocation outputs: the valid mask is registered, the register number
    // is the freelist's registered pop data, zeroed on idle slots.
    assign rn_alloc_valid          = r_alloc_valid;
    assign rn_alloc_reg[0 +: AW]   = r_alloc_valid[0] ? fl_pop_reg[0 +: AW]  : '0;
    assign rn_alloc_reg[AW +: AW]  = r_alloc_valid[1] ? fl_pop_reg[AW +: AW] : '0;

    assign flush_busy = (r_state == ST_RECOVER);

    // Push port: ring walk in RECOVER, release queue in RUN.
    always_comb begin
        fl_push_en  = 2'b00;
        fl_push_reg = '0;
        if (r_state == ST_RECOVER) begin
            fl_push_en[0] = (w_rec_n != '0);
            fl_push_en[1] = (w_rec_n == C_RING_TWO);
            if (fl_push_en[0]) fl_push_reg[0 +: AW]  = w_rec_d0;
            if (fl_push_en[1]) fl_push_reg[AW +: AW] = w_rec_d1;
        end else begin
            fl_push_en[0] = (w_deq_n != '0);
            fl_push_en[1] = (w_deq_n == C_RQ_TWO);
            if (fl_push_en[0]) fl_push_reg[0 +: AW]  = r_relq[r_rq_rd];
            if (fl_push_en[1]) fl_push_reg[AW +: AW] = r_relq[w_rq_rd1];
        end
    end

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (flush && (w_cnt_post != '0)) w_state_nxt = ST_RECOVER;
            end
            ST_RECOVER: begin
                // Last pairs leave this cycle; RUN resumes on the next one.
                if (r_ring_cnt == w_rec_n) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_alloc_valid <= 2'b00;
            r_head        <= '0;
            r_tail        <= '0;
            r_ring_cnt    <= '0;
            r_rq_wr       <= '0;
            r_rq_rd       <= '0;
            r_rq_cnt      <= '0;
        end else begin
            r_alloc_valid <= fl_pop_en;
            // No pop data can arrive in RECOVER (no grants there or on the
            // flush cycle), so writes and the recovery walk never overlap.
            r_head        <= r_head + w_wr_n[IPW-1:0] - w_rec_n[IPW-1:0];
            r_tail        <= r_tail + w_ret_n[IPW-1:0];
            r_ring_cnt    <= w_cnt_post - w_rec_n;
            r_rq_wr       <= r_rq_wr + w_enq_n[QPW-1:0];
            r_rq_rd       <= r_rq_rd + w_deq_n[QPW-1:0];
            r_rq_cnt      <= r_rq_cnt + w_enq_n - w_deq_n;
        end
    end

    // Storage arrays carry no reset; occupancy counters qualify every read.
    always_ff @(posedge clk) begin
        if (w_wr_n != '0) r_ring[r_head] <= w_wr_d0;
        if (w_wr_n == C_RING_TWO) r_ring[r_head + IPW'(1)] <= w_wr_d1;
    end

    always_ff @(posedge clk) begin
        if (w_enq_n != '0) r_relq[r_rq_wr] <= w_enq_d0;
        if (w_enq_n == C_RQ_TWO) r_relq[r_rq_wr + QPW'(1)] <= w_enq_d1;
    end

`ifdef FREELIST_CTRL_STATS_EN
    // -----------------------------------------------------------------------
    // Saturating statistics
    // -----------------------------------------------------------------------
    logic [31:0] r_stat_alloc_stall;
    logic [31:0] r_stat_recovered;
    logic [32:0] w_rec_sum;

    assign w_rec_sum = {1'b0, r_stat_recovered} + 33'(w_rec_n);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stat_alloc_stall <= '0;
            r_stat_recovered   <= '0;
        end else begin
            if ((rn_req != 2'b00) && !rn_ready && (r_stat_alloc_stall != '1)) begin
                r_stat_alloc_stall <= r_stat_alloc_stall + 32'd1;
            end
            r_stat_recovered <= w_rec_sum[32] ? '1 : w_rec_sum[31:0];
        end
    end

    assign stat_alloc_stall = r_stat_alloc_stall;
    assign stat_recovered   = r_stat_recovered;
`endif

endmodule

// File: tb/tb_freelist_ctrl.sv
// ---------------------------------------------------------------------------
// tb_freelist_ctrl
//
// Directed bench for freelist_ctrl. The bench plays the freelist itself by
// presenting pop data on fl_pop_reg the cycle after a grant. Inputs change
// 1 time unit after the rising edge; outputs are sampled on the falling edge
// (or 1 unit after the rising edge for registered state).
// ---------------------------------------------------------------------------
module tb_freelist_ctrl;

    localparam int DW = 2;
    localparam int AW = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic [DW-1:0]    rn_req;
    logic             rn_ready;
    logic [DW-1:0]    rn_alloc_valid;
    logic [DW*AW-1:0] rn_alloc_reg;
    logic [DW-1:0]    cm_retire_en;
    logic [DW-1:0]    cm_free_en;
    logic [DW*AW-1:0] cm_free_reg;
    logic             cm_ready;
    logic             flush;
    logic             flush_busy;
    logic [DW-1:0]    fl_pop_en;
    logic [DW*AW-1:0] fl_pop_reg;
    logic             fl_empty;
    logic [DW-1:0]    fl_push_en;
    logic [DW*AW-1:0] fl_push_reg;

    int n_checks = 0;
    int n_errors = 0;

    // Expected freelist pushes, oldest first.
    logic [AW-1:0] exp_q[$];

    freelist_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .rn_req         (rn_req),
        .rn_ready       (rn_ready),
        .rn_alloc_valid (rn_alloc_valid),
        .rn_alloc_reg   (rn_alloc_reg),
        .cm_retire_en   (cm_retire_en),
        .cm_free_en     (cm_free_en),
        .cm_free_reg    (cm_free_reg),
        .cm_ready       (cm_ready),
        .flush          (flush),
        .flush_busy     (flush_busy),
        .fl_pop_en      (fl_pop_en),
        .fl_pop_reg     (fl_pop_reg),
        .fl_empty       (fl_empty),
        .fl_push_en     (fl_push_en),
        .fl_push_reg    (fl_push_reg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Both push slots active, data taken from the expected queue.
    task automatic check_push_pair(input string tag);
        logic [AW-1:0] e0;
        logic [AW-1:0] e1;
        e0 = exp_q.pop_front();
        e1 = exp_q.pop_front();
        check({tag, ".en"}, 32'(fl_push_en), 32'(2'b11));
        check({tag, ".s0"}, 32'(fl_push_reg[AW-1:0]), 32'(e0));
        check({tag, ".s1"}, 32'(fl_push_reg[2*AW-1:AW]), 32'(e1));
    endtask

    // ---------------- drivers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rn_req       = '0;
        cm_retire_en = '0;
        cm_free_en   = '0;
        cm_free_reg  = '0;
        flush        = 1'b0;
        fl_empty     = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".alloc_valid"}, 32'(rn_alloc_valid), 0);
        check({tag, ".alloc_reg"},   32'(rn_alloc_reg), 0);
        check({tag, ".pop_en"},      32'(fl_pop_en), 0);
        check({tag, ".push_en"},     32'(fl_push_en), 0);
        check({tag, ".push_reg"},    32'(fl_push_reg), 0);
        check({tag, ".busy"},        32'(flush_busy), 0);
        check({tag, ".cm_ready"},    32'(cm_ready), 1);
        check({tag, ".ring_cnt"},    32'(dut.r_ring_cnt), 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        n_errors++;
        $display("FAIL watchdog: time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        rst        = 1'b0;
        fl_pop_reg = '0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        next_cycle();

        // Two-slot allocation: pop same cycle, data and valid next cycle.
        rn_req = 2'b11;
        @(negedge clk);
        check("t1.ready", 32'(rn_ready), 1);
        check("t1.pop_en", 32'(fl_pop_en), 32'(2'b11));
        next_cycle();
        rn_req     = 2'b00;
        fl_pop_reg = {6'd11, 6'd10};
        @(negedge clk);
        check("t1.valid", 32'(rn_alloc_valid), 32'(2'b11));
        check("t1.reg", 32'(rn_alloc_reg), 32'({6'd11, 6'd10}));
        next_cycle();
        check("t1.ring_cnt", 32'(dut.r_ring_cnt), 2);
        check("t1.valid_drop", 32'(rn_alloc_valid), 0);
        cm_retire_en = 2'b11;
        next_cycle();
        cm_retire_en = 2'b00;
        check("t1.cnt_retired", 32'(dut.r_ring_cnt), 0);

        // Freelist empty blocks the whole group.
        fl_empty = 1'b1;
        rn_req   = 2'b01;
        @(negedge clk);
        check("t2.ready", 32'(rn_ready), 0);
        check("t2.pop_en", 32'(fl_pop_en), 0);
        next_cycle();
        fl_empty = 1'b0;
        rn_req   = 2'b00;
        @(negedge clk);
        check("t2.valid", 32'(rn_alloc_valid), 0);
        next_cycle();

        // Slot-1-only allocation, then flush recovers it on push slot 0.
        rn_req = 2'b10;
        @(negedge clk);
        check("t2b.pop_en", 32'(fl_pop_en), 32'(2'b10));
        next_cycle();
        rn_req     = 2'b00;
        fl_pop_reg = {6'd33, 6'd7};
        @(negedge clk);
        check("t2b.valid", 32'(rn_alloc_valid), 32'(2'b10));
        check("t2b.reg1", 32'(rn_alloc_reg[2*AW-1:AW]), 33);
        next_cycle();
        check("t2b.ring_cnt", 32'(dut.r_ring_cnt), 1);
        flush = 1'b1;
        @(negedge clk);
        check("t2b.busy_flush_cycle", 32'(flush_busy), 0);
        check("t2b.ready_flush_cycle", 32'(rn_ready), 0);
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        check("t2b.busy", 32'(flush_busy), 1);
        check("t2b.push_en", 32'(fl_push_en), 32'(2'b01));
        check("t2b.push_s0", 32'(fl_push_reg[AW-1:0]), 33);
        next_cycle();
        @(negedge clk);
        check("t2b.busy_done", 32'(flush_busy), 0);
        check("t2b.push_idle", 32'(fl_push_en), 0);
        check("t2b.ring_cnt_done", 32'(dut.r_ring_cnt), 0);
        next_cycle();

        // Allocate 1..5, retire 1,2, flush: pushes {5,4} then {3}.
        rn_req = 2'b11;
        next_cycle();
        rn_req     = 2'b11;
        fl_pop_reg = {6'd2, 6'd1};
        next_cycle();
        rn_req     = 2'b01;
        fl_pop_reg = {6'd4, 6'd3};
        next_cycle();
        rn_req     = 2'b00;
        fl_pop_reg = {6'd63, 6'd5};
        @(negedge clk);
        check("t3.valid_single", 32'(rn_alloc_valid), 32'(2'b01));
        next_cycle();
        cm_retire_en = 2'b11;
        next_cycle();
        cm_retire_en = 2'b00;
        flush        = 1'b1;
        @(negedge clk);
        check("t3.ring_cnt", 32'(dut.r_ring_cnt), 3);
        check("t3.busy_flush_cycle", 32'(flush_busy), 0);
        exp_q.push_back(6'd5);
        exp_q.push_back(6'd4);
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        check("t3.busy1", 32'(flush_busy), 1);
        check("t3.ready_rec", 32'(rn_ready), 0);
        check_push_pair("t3.rec1");
        next_cycle();
        @(negedge clk);
        check("t3.busy2", 32'(flush_busy), 1);
        check("t3.push_en2", 32'(fl_push_en), 32'(2'b01));
        check("t3.push_s0_2", 32'(fl_push_reg[AW-1:0]), 3);
        next_cycle();
        @(negedge clk);
        check("t3.busy3", 32'(flush_busy), 0);
        check("t3.push_idle", 32'(fl_push_en), 0);
        check("t3.ready_back", 32'(rn_ready), 1);
        next_cycle();

        // Ten allocations, flush on the last data cycle; releases during
        // RECOVER fill the queue, which drains once RUN resumes.
        for (int i = 0; i < 6; i++) begin
            rn_req     = (i < 5) ? 2'b11 : 2'b00;
            flush      = (i == 5);
            fl_pop_reg = (i > 0) ? {6'(40 + 2*i - 1), 6'(40 + 2*i - 2)} : '0;
            next_cycle();
        end
        flush = 1'b0;
        for (int r = 49; r >= 40; r--) exp_q.push_back(6'(r));
        for (int k = 0; k < 5; k++) begin
            cm_free_en  = 2'b11;
            cm_free_reg = {6'(60 + 2*k + 1), 6'(60 + 2*k)};
            @(negedge clk);
            check($sformatf("t4.busy%0d", k), 32'(flush_busy), 1);
            check($sformatf("t4.cm_ready%0d", k), 32'(cm_ready), (k < 2) ? 1 : 0);
            check_push_pair($sformatf("t4.rec%0d", k));
            next_cycle();
        end
        cm_free_en  = 2'b00;
        cm_free_reg = '0;
        for (int r = 60; r < 64; r++) exp_q.push_back(6'(r));
        @(negedge clk);
        check("t4.busy_run", 32'(flush_busy), 0);
        check("t4.cm_ready_full", 32'(cm_ready), 0);
        check_push_pair("t4.rq1");
        next_cycle();
        @(negedge clk);
        check("t4.cm_ready_back", 32'(cm_ready), 1);
        check_push_pair("t4.rq2");
        next_cycle();
        @(negedge clk);
        check("t4.push_idle", 32'(fl_push_en), 0);
        next_cycle();

        // Flush on the cycle two popped registers arrive, ring otherwise empty.
        rn_req = 2'b11;
        next_cycle();
        rn_req     = 2'b00;
        fl_pop_reg = {6'd23, 6'd22};
        flush      = 1'b1;
        @(negedge clk);
        check("t5.busy_flush_cycle", 32'(flush_busy), 0);
        next_cycle();
        flush = 1'b0;
        exp_q.push_back(6'd23);
        exp_q.push_back(6'd22);
        @(negedge clk);
        check("t5.busy", 32'(flush_busy), 1);
        check_push_pair("t5.rec");
        next_cycle();
        @(negedge clk);
        check("t5.busy_done", 32'(flush_busy), 0);
        check("t5.push_idle", 32'(fl_push_en), 0);
        check("t5.ring_cnt", 32'(dut.r_ring_cnt), 0);
        next_cycle();

        // Retire and flush together: only the survivors are recovered.
        rn_req = 2'b11;
        next_cycle();
        rn_req     = 2'b01;
        fl_pop_reg = {6'd31, 6'd30};
        next_cycle();
        rn_req     = 2'b00;
        fl_pop_reg = {6'd0, 6'd32};
        next_cycle();
        cm_retire_en = 2'b01;
        flush        = 1'b1;
        next_cycle();
        cm_retire_en = 2'b00;
        flush        = 1'b0;
        exp_q.push_back(6'd32);
        exp_q.push_back(6'd31);
        @(negedge clk);
        check("t6.busy", 32'(flush_busy), 1);
        check_push_pair("t6.rec");
        next_cycle();
        @(negedge clk);
        check("t6.busy_done", 32'(flush_busy), 0);
        next_cycle();

        // Reset in the middle of RECOVER.
        rn_req = 2'b11;
        next_cycle();
        fl_pop_reg = {6'd51, 6'd50};
        next_cycle();
        fl_pop_reg = {6'd53, 6'd52};
        next_cycle();
        rn_req     = 2'b00;
        fl_pop_reg = {6'd55, 6'd54};
        flush      = 1'b1;
        next_cycle();
        flush       = 1'b0;
        cm_free_en  = 2'b01;
        cm_free_reg = {6'd0, 6'd9};
        @(negedge clk);
        check("t7.busy", 32'(flush_busy), 1);
        next_cycle();
        cm_free_en  = 2'b00;
        cm_free_reg = '0;
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("t7.rst");
        check("t7.rq_cnt", 32'(dut.r_rq_cnt), 0);
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
        @(negedge clk);
        check("t7.busy_after", 32'(flush_busy), 0);
        check("t7.push_after", 32'(fl_push_en), 0);
        check("t7.ready_after", 32'(rn_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/freelist_ctrl.md
# freelist_ctrl

Sequencer in front of the physical-register `freelist`. It grants rename allocation requests all-or-nothing and returns popped register numbers one cycle later. It queues commit-time releases into the freelist push port. It tracks every uncommitted allocation in an in-flight ring so that, on a pipeline flush, it walks the ring and returns those registers to the freelist two per cycle. It sits between rename/commit and `freelist`, and is the only driver of the freelist push/pop ports.

## Interface
- `DISPATCH_WIDTH`, 2: slots per cycle. Fixed at 2, matching the freelist.
- `PHYS_REGS`, 64: physical registers.
- `PHYS_REGS_ADDR_WIDTH`, 6: `$clog2(PHYS_REGS)`.
- `INFLIGHT_DEPTH`, 32: in-flight ring entries, power of 2.
- `RELQ_DEPTH`, 4: release queue entries, power of 2.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `rn_req` in DW: per-slot allocation request.
- `rn_ready` out 1: grant for all requested slots this cycle.
- `rn_alloc_valid` out DW: allocated register valid for the slot.
- `rn_alloc_reg` out DW×AW: allocated register number.
- `cm_retire_en` in DW: slot commits; retires the oldest ring entry per set bit.
- `cm_free_en` in DW: slot releases an old mapping.
- `cm_free_reg` in DW×AW: register number released by the slot.
- `cm_ready` out 1: release queue can take 2 entries.
- `flush` in 1: discard all uncommitted allocations.
- `flush_busy` out 1: recovery in progress.
- `fl_pop_en` out DW: freelist pop request.
- `fl_pop_reg` in DW×AW: freelist pop data, registered by the freelist.
- `fl_empty` in 1: freelist cannot serve a full dispatch group.
- `fl_push_en` out DW: freelist push request.
- `fl_push_reg` out DW×AW: freelist push data.

## Operation
- States: RUN, RECOVER. Reset enters RUN.
- Reset values:
  - all rings and queues empty; ring count 0;
  - `rn_alloc_valid`=0, `rn_alloc_reg`=0;
  - `fl_pop_en`=0, `fl_push_en`=0, `fl_push_reg`=0;
  - `flush_busy`=0, `cm_ready`=1.
- `rn_ready` = RUN ∧ ¬`flush` ∧ ¬`fl_empty` ∧ ring free slots ≥ 2.
  - The free-slot check uses the count after this cycle's arriving allocations.
- Allocation: `fl_pop_en` = `rn_req` when `rn_ready`, else 0.
  - `rn_req`=2'b10 pops into slot 1, per the freelist's compaction.
- Arriving pop data (cycle after `fl_pop_en`):
  - drives `rn_alloc_valid`/`rn_alloc_reg` for the requested slots;
  - is written to the ring head in slot order (slot 0 first);
  - is written even if `flush` is asserted that cycle.
- Retire: popcount(`cm_retire_en`) entries are removed from the ring tail. `cm_retire_en` must be 0 in RECOVER.
- Release queue:
  - each set `cm_free_en` enqueues its register, slot 0 first, when `cm_ready`;
  - in RUN, up to 2 queue entries per cycle drive `fl_push_en`/`fl_push_reg`, lowest slot first;
  - `cm_ready` = free queue entries ≥ 2.
- Flush: accepted in RUN only.
  - If the post-write ring count is > 0, go to RECOVER; otherwise stay in RUN.
- RECOVER:
  - each cycle pops min(2, count) newest ring entries (from the head) onto the push port;
  - the release queue holds, but still accepts enqueues;
  - when the count reaches 0, return to RUN the next cycle.
- `flush_busy` = (state == RECOVER).
- Pointers wrap modulo depth. Count widths are log2(depth)+1.

## Timing
- Allocation: request at N → `rn_alloc_valid` at N+1. `rn_alloc_valid` is a registered output.
- Release: enqueue at N → earliest push at N+1 (RUN only).
- Recovery: flush at N → RECOVER from N+1 → k ring entries take ceil(k/2) cycles → RUN on the cycle after the last push.
- Simultaneous retire and allocation write in the same cycle: both are applied; count = count + writes − retires.
- Retire and flush in the same cycle: retire is applied first; only the remaining entries are recovered.
- Reset mid-RECOVER: state returns to RUN at once and all contents are discarded.

## Configuration
- `FREELIST_CTRL_STATS_EN` defined: adds 32-bit saturating counters, readable via outputs `stat_alloc_stall` and `stat_recovered`.
  - `stat_alloc_stall` counts cycles with `rn_req`≠0 ∧ ¬`rn_ready`.
  - `stat_recovered` counts registers returned in RECOVER.
  - Both reset to 0.
- Macro undefined: counters and ports are absent; behaviour is otherwise identical.

## Test plan
- After reset, `rn_req`=2'b11 → `fl_pop_en`=2'b11 the same cycle; next cycle `rn_alloc_valid`=2'b11 with `fl_pop_reg` values; ring count=2.
- `fl_empty`=1 with `rn_req`=2'b01 → `rn_ready`=0, `fl_pop_en`=0, `rn_alloc_valid`=0 the next cycle.
- Allocate 5 registers, retire 2, then flush → `flush_busy` high for 2 cycles; pushes the newest 2, then the last 1; `flush_busy` low on the 3rd cycle; `rn_ready` returns.
- Five consecutive `cm_free_en`=2'b11 during RECOVER → `cm_ready` drops after the 2nd cycle; queue pushes start the first RUN cycle, 2 per cycle.
- Flush in the same cycle that 2 popped registers arrive, ring otherwise empty → RECOVER lasts 1 cycle and pushes both registers.
- Assert `rst` low mid-RECOVER → all outputs return to reset values immediately and the ring count is 0.
